prelude_sequencer: RTL and testbench

- Multi-cycle control FSM for the prelude 8-bit core.
- Owns the program counter and instruction register, fetches from the combinational instruction ROM, and decodes the 2-bit instruction class.
- Drives register-file, ALU and write-source selects to the datapath.
- Sequences rio_in/rio_out transfers with valid/ready handshakes.
- Provides run/step control for bring-up.

---
 rtl/prelude_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_prelude_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prelude_sequencer.sv
`timescale 1ns/1ps
// prelude_sequencer: multi-cycle control FSM for the prelude 8-bit core.
// Owns PC and IR, fetches from a combinational ROM, decodes the 2-bit
// instruction class and sequences rio_in/rio_out handshakes.
//
// Handshake semantics: a transfer happens in a cycle only when both sides
// agree in that same cycle. For rio_in, in_ready is high exactly in the
// commit cycle of a src=6 copy, so in_valid && in_ready is the consume
// event. For rio_out, out_valid && out_ready is the accept event. out_valid
// for a non-rio_in source is held high while waiting for out_ready. For the
// rio_in -> rio_out pass-through, both strobes rise together only when
// in_valid and out_ready are both high.
module prelude_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  output logic       halted,
  output logic [7:0] instr_addr,
  input  logic [7:0] instr_data,
  output logic [2:0] rd_a_sel,
  output logic [2:0] rd_b_sel,
  output logic       reg_we,
  output logic [2:0] reg_wr_sel,
  output logic [1:0] wr_src,
  output logic [7:0] imm,
  output logic [2:0] alu_op,
  input  logic [7:0] r0_val,
  input  logic [7:0] r3_val,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       retire,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WAIT_OUT = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic       r_step_mode, w_step_mode_nxt;

  logic [7:0] w_pc_inc;
  logic [7:0] w_pc_commit;
  logic       w_exec;
  logic       w_commit;
  logic       w_cond_base;
  logic       w_taken;
  logic [2:0] w_src;
  logic [2:0] w_dst;

  assign w_pc_inc   = r_pc + 8'd1;
  assign w_src      = r_ir[5:3];
  assign w_dst      = r_ir[2:0];
  // Reset in the same cycle suppresses every strobe of the instruction.
  assign w_exec     = rst_n && (r_state == S_EXEC || r_state == S_WAIT_IN ||
                                r_state == S_WAIT_OUT);
  assign halted     = (r_state == S_IDLE);
  assign instr_addr = r_pc;
  assign dbg_state  = r_state;
  assign retire     = w_commit;

  // Branch condition: low two bits pick a base test, bit 2 inverts it.
  always_comb begin
    case (r_ir[1:0])
      2'b00:   w_cond_base = 1'b0;
      2'b01:   w_cond_base = (r3_val == 8'h00);
      2'b10:   w_cond_base = r3_val[7];
      default: w_cond_base = r3_val[7] || (r3_val == 8'h00);
    endcase
  end

  assign w_taken = w_cond_base ^ r_ir[2];

  // Instruction decode: datapath selects, strobes and commit condition.
  always_comb begin
    rd_a_sel    = 3'd0;
    rd_b_sel    = 3'd0;
    reg_we      = 1'b0;
    reg_wr_sel  = 3'd0;
    wr_src      = 2'b00;
    imm         = {2'b00, r_ir[5:0]};
    alu_op      = 3'd0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_commit    = 1'b0;
    w_pc_commit = w_pc_inc;
    if (w_exec) begin
      case (r_ir[7:6])
        2'b00: begin
          reg_we   = 1'b1;
          w_commit = 1'b1;
        end
        2'b01: begin
          rd_a_sel   = 3'd1;
          rd_b_sel   = 3'd2;
          alu_op     = r_ir[2:0];
          reg_we     = 1'b1;
          reg_wr_sel = 3'd3;
          wr_src     = 2'b01;
          w_commit   = 1'b1;
        end
        2'b10: begin
          w_commit = ((w_src != 3'd6) || in_valid) &&
                     ((w_dst != 3'd6) || out_ready);
          if (w_src == 3'd6) begin
            wr_src   = 2'b11;
            in_ready = w_commit;
          end else if (w_src == 3'd7) begin
            wr_src = 2'b00;
            imm    = 8'h00;
          end else begin
            wr_src   = 2'b10;
            rd_a_sel = w_src;
          end
          reg_wr_sel = w_dst;
          reg_we     = w_commit && (w_dst < 3'd6);
          out_valid  = (w_dst == 3'd6) && (w_commit || (w_src != 3'd6));
        end
        default: begin
          w_commit    = 1'b1;
          w_pc_commit = w_taken ? r0_val : w_pc_inc;
        end
      endcase
    end
  end

  // Next-state logic for the control FSM, PC, IR and step latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_step_mode_nxt = r_step_mode;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt     = S_FETCH;
          w_step_mode_nxt = 1'b0;
        end else if (step) begin
          w_state_nxt     = S_FETCH;
          w_step_mode_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        w_ir_nxt    = instr_data;
        w_state_nxt = S_EXEC;
      end
      S_EXEC, S_WAIT_IN, S_WAIT_OUT: begin
        if (w_commit) begin
          w_pc_nxt        = w_pc_commit;
          w_step_mode_nxt = 1'b0;
          w_state_nxt     = (run && !r_step_mode) ? S_FETCH : S_IDLE;
        end else begin
          w_state_nxt = (w_src == 3'd6) ? S_WAIT_IN : S_WAIT_OUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= PC_RESET;
      r_ir        <= 8'h00;
      r_step_mode <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_step_mode <= w_step_mode_nxt;
    end
  end

endmodule

// File: tb/tb_prelude_sequencer.sv
`timescale 1ns/1ps
// Bench for prelude_sequencer: directed table of single-step instructions,
// hand sequences for run/step, IO stalls, PC wrap and reset, then a random
// free-run compared against an instruction-level reference model.
module tb_prelude_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, step, halted;
  logic [7:0] instr_addr, instr_data;
  logic [2:0] rd_a_sel, rd_b_sel, reg_wr_sel, alu_op, dbg_state;
  logic       reg_we, in_valid, in_ready, out_valid, out_ready, retire;
  logic [1:0] wr_src;
  logic [7:0] imm, r0_val, r3_val;

  logic [7:0] rom [0:255];
  assign instr_data = rom[instr_addr];

  int checks = 0;
  int errors = 0;

  prelude_sequencer #(.PC_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halted(halted),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .reg_we(reg_we),
    .reg_wr_sel(reg_wr_sel), .wr_src(wr_src), .imm(imm), .alu_op(alu_op),
    .r0_val(r0_val), .r3_val(r3_val), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .retire(retire), .dbg_state(dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_halted(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("halt_wait", halted, 1'b1);
  endtask

  // Expected behaviour of one execute-phase cycle, stated per instruction class.
  typedef struct packed {
    logic       commit;
    logic       we;
    logic [2:0] wsel;
    logic [1:0] src;
    logic       in_rdy;
    logic       ov;
    logic [7:0] imm;
    logic [7:0] next_pc;
  } exp_t;

  function automatic exp_t model_exec(input logic [7:0] ir, input logic [7:0] r3,
                                      input logic [7:0] r0, input logic iv,
                                      input logic ordy, input logic [7:0] pc);
    exp_t e;
    int   v, s, d;
    logic t;
    logic need_in, need_out;
    e = '0;
    e.next_pc = pc + 8'd1;
    e.imm = {2'b00, ir[5:0]};
    v = $signed(r3);
    s = ir[5:3];
    d = ir[2:0];
    t = 1'b0;
    case (ir[7:6])
      2'b00: begin e.commit = 1; e.we = 1; e.wsel = 0; e.src = 2'b00; end
      2'b01: begin e.commit = 1; e.we = 1; e.wsel = 3; e.src = 2'b01; end
      2'b10: begin
        need_in  = (s == 6);
        need_out = (d == 6);
        e.commit = (!need_in || iv) && (!need_out || ordy);
        e.src    = (s < 6) ? 2'b10 : ((s == 6) ? 2'b11 : 2'b00);
        if (s == 7) e.imm = 8'h00;
        e.we     = e.commit && (d < 6);
        e.wsel   = d[2:0];
        e.in_rdy = need_in && e.commit;
        e.ov     = need_out && (e.commit || !need_in);
      end
      default: begin
        case (ir[2:0])
          3'd0: t = 0;
          3'd1: t = (v == 0);
          3'd2: t = (v < 0);
          3'd3: t = (v <= 0);
          3'd4: t = 1;
          3'd5: t = (v != 0);
          3'd6: t = (v >= 0);
          default: t = (v > 0);
        endcase
        e.commit = 1;
        if (t) e.next_pc = r0;
      end
    endcase
    return e;
  endfunction

  typedef struct packed {
    logic [7:0] ir, r3, r0;
    logic       iv, ordy;
    logic       we;
    logic [2:0] wsel;
    logic [1:0] src;
    logic [7:0] imm;
    logic [2:0] rda, rdb, alu;
    logic       in_rdy, ov, taken;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [7:0] cur_pc, exp_pc, m_pc, m_ir;
    int         cnt, i;
    logic       m_idle, m_fetch;
    exp_t       e;
    vec_t       v;

    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    //          ir     r3     r0     iv    ordy  we    wsel  src    imm    rda   rdb   alu   ird   ov    tk
    vecs[0]  = '{8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 8'h05, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h3F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 8'h3F, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h4D, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 2'b01, 8'h0D, 3'd1, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h9A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 2'b10, 8'h1A, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'hB9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 2'b00, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hB5, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 2'b11, 8'h35, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h8E, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd6, 2'b10, 8'h0E, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h87, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 2'b10, 8'h07, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'hC1, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h01, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'hC2, 8'h80, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h02, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'hC7, 8'h80, 8'h20, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h07, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'hC0, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'hC3, 8'h01, 8'h30, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h03, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'hC3, 8'h00, 8'h60, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h03, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'hC5, 8'hFF, 8'h22, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h05, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'hC6, 8'h7F, 8'h33, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h06, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{8'hC4, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'h04, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 8'h01, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst_n = 1'b0; run = 1'b0; step = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    r0_val = 8'h00; r3_val = 8'h00;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_halted", halted, 1'b1);
    chk("rst_pc", instr_addr, 8'h00);
    chk("rst_retire", retire, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);

    // Free-run of {05, 7F, C4}, then run drops mid-instruction.
    rom[0] = 8'h05; rom[1] = 8'h7F; rom[2] = 8'hC4; rom[5] = 8'h2A;
    @(negedge clk); rst_n = 1'b1; run = 1'b1; r0_val = 8'h05; #1;
    chk("a_idle", halted, 1'b1);
    @(negedge clk); #1;
    chk("a_f0_addr", instr_addr, 8'h00); chk("a_f0_retire", retire, 1'b0);
    @(negedge clk); #1;
    chk("a_e0_we", reg_we, 1'b1); chk("a_e0_wsel", reg_wr_sel, 3'd0);
    chk("a_e0_imm", imm, 8'h05); chk("a_e0_src", wr_src, 2'b00); chk("a_e0_retire", retire, 1'b1);
    @(negedge clk); #1;
    chk("a_f1_addr", instr_addr, 8'h01); chk("a_f1_retire", retire, 1'b0);
    @(negedge clk); #1;
    chk("a_e1_imm", imm, 8'h3F); chk("a_e1_we", reg_we, 1'b1); chk("a_e1_wsel", reg_wr_sel, 3'd3);
    chk("a_e1_src", wr_src, 2'b01); chk("a_e1_alu", alu_op, 3'd7);
    chk("a_e1_rda", rd_a_sel, 3'd1); chk("a_e1_rdb", rd_b_sel, 3'd2); chk("a_e1_retire", retire, 1'b1);
    @(negedge clk); #1;
    chk("a_f2_addr", instr_addr, 8'h02);
    @(negedge clk); #1;
    chk("a_e2_retire", retire, 1'b1); chk("a_e2_we", reg_we, 1'b0);
    @(negedge clk); run = 1'b0; #1;
    chk("a_branch_addr", instr_addr, 8'h05); chk("a_f3_halted", halted, 1'b0);
    @(negedge clk); #1;
    chk("a_e3_retire", retire, 1'b1); chk("a_e3_imm", imm, 8'h2A);
    @(negedge clk); #1;
    chk("a_stop_halted", halted, 1'b1); chk("a_stop_addr", instr_addr, 8'h06);
    cur_pc = 8'h06;

    // Table of single-stepped instructions, each committing in its EXEC cycle.
    for (i = 0; i < 18; i++) begin
      v = vecs[i];
      @(negedge clk);
      rom[cur_pc] = v.ir; r3_val = v.r3; r0_val = v.r0;
      in_valid = v.iv; out_ready = v.ordy; step = 1'b1; #1;
      chk("t_idle", halted, 1'b1);
      @(negedge clk); step = 1'b0; #1;
      chk("t_fetch_retire", retire, 1'b0);
      @(negedge clk); #1;
      chk("t_retire", retire, 1'b1);
      chk("t_reg_we", reg_we, v.we);
      chk("t_in_ready", in_ready, v.in_rdy);
      chk("t_out_valid", out_valid, v.ov);
      chk("t_imm", imm, v.imm);
      if (v.we || v.ov) chk("t_wr_src", wr_src, v.src);
      if (v.we) chk("t_wr_sel", reg_wr_sel, v.wsel);
      if ((v.we || v.ov) && (v.src == 2'b01 || v.src == 2'b10)) chk("t_rd_a", rd_a_sel, v.rda);
      if (v.we && v.src == 2'b01) begin
        chk("t_rd_b", rd_b_sel, v.rdb);
        chk("t_alu_op", alu_op, v.alu);
      end
      exp_pc = v.taken ? v.r0 : cur_pc + 8'd1;
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
      chk("t_halted", halted, 1'b1);
      chk("t_next_pc", instr_addr, exp_pc);
      cur_pc = exp_pc;
    end
    chk("pc_wrap", instr_addr, 8'h00);

    // Copy rio_in -> r0 stalled for three wait cycles.
    @(negedge clk); rom[cur_pc] = 8'hB0; in_valid = 1'b0; step = 1'b1; #1;
    @(negedge clk); step = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("wi_reg_we", reg_we, 1'b0); chk("wi_retire", retire, 1'b0);
      chk("wi_in_ready", in_ready, 1'b0); chk("wi_addr", instr_addr, cur_pc);
      chk("wi_halted", halted, 1'b0);
    end
    @(negedge clk); in_valid = 1'b1; #1;
    chk("wi_c_in_ready", in_ready, 1'b1); chk("wi_c_reg_we", reg_we, 1'b1);
    chk("wi_c_retire", retire, 1'b1); chk("wi_c_src", wr_src, 2'b11); chk("wi_c_wsel", reg_wr_sel, 3'd0);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("wi_halted_end", halted, 1'b1); chk("wi_pc", instr_addr, cur_pc + 8'd1);
    cur_pc = cur_pc + 8'd1;

    // Pass-through rio_in -> rio_out needs both sides in one cycle.
    @(negedge clk); rom[cur_pc] = 8'hB6; step = 1'b1; #1;
    @(negedge clk); step = 1'b0; #1;
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b0; #1;
    chk("pt_a_in_ready", in_ready, 1'b0); chk("pt_a_out_valid", out_valid, 1'b0); chk("pt_a_retire", retire, 1'b0);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("pt_b_in_ready", in_ready, 1'b0); chk("pt_b_out_valid", out_valid, 1'b0); chk("pt_b_retire", retire, 1'b0);
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("pt_c_in_ready", in_ready, 1'b1); chk("pt_c_out_valid", out_valid, 1'b1);
    chk("pt_c_retire", retire, 1'b1); chk("pt_c_reg_we", reg_we, 1'b0);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("pt_halted", halted, 1'b1); chk("pt_pc", instr_addr, cur_pc + 8'd1);
    cur_pc = cur_pc + 8'd1;

    // Step held high during run is ignored; a lone step retires exactly one.
    for (int a = 0; a < 256; a++) rom[a] = 8'h01;
    @(negedge clk); run = 1'b1; step = 1'b1; #1;
    chk("rs_idle", halted, 1'b1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("rs_running", halted, 1'b0);
      if (retire === 1'b1) cnt++;
    end
    chk("rs_retires", cnt[15:0], 16'd4);
    @(negedge clk); run = 1'b0; step = 1'b0; #1;
    wait_halted(10);
    chk("rs_pc", instr_addr, cur_pc + 8'd5);
    cur_pc = cur_pc + 8'd5;
    @(negedge clk); step = 1'b1; #1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); step = 1'b0; #1;
      if (retire === 1'b1) cnt++;
    end
    chk("step_retires", cnt[15:0], 16'd1);
    chk("step_halted", halted, 1'b1);
    chk("step_pc", instr_addr, cur_pc + 8'd1);
    cur_pc = cur_pc + 8'd1;

    // Random free-run against the instruction-level model.
    for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
    m_pc = cur_pc; m_ir = 8'h00; m_idle = 1'b1; m_fetch = 1'b0;
    i = 0;
    while (i < 500 || (!m_idle && i < 700)) begin
      @(negedge clk);
      run = (i < 500);
      r0_val = 8'($urandom); r3_val = 8'($urandom);
      in_valid  = (i < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = (i < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("r_addr", instr_addr, m_pc);
      if (m_idle) begin
        chk("r_idle_halted", halted, 1'b1);
        chk("r_idle_retire", retire, 1'b0);
        if (run) begin m_idle = 1'b0; m_fetch = 1'b1; end
      end else if (m_fetch) begin
        chk("r_fetch_halted", halted, 1'b0);
        chk("r_fetch_retire", retire, 1'b0);
        chk("r_fetch_reg_we", reg_we, 1'b0);
        chk("r_fetch_out_valid", out_valid, 1'b0);
        m_ir = rom[m_pc];
        m_fetch = 1'b0;
      end else begin
        e = model_exec(m_ir, r3_val, r0_val, in_valid, out_ready, m_pc);
        chk("r_retire", retire, e.commit);
        chk("r_reg_we", reg_we, e.we);
        chk("r_in_ready", in_ready, e.in_rdy);
        chk("r_out_valid", out_valid, e.ov);
        chk("r_imm", imm, e.imm);
        if (e.we) chk("r_wr_sel", reg_wr_sel, e.wsel);
        if (e.we || e.ov) chk("r_wr_src", wr_src, e.src);
        if (e.commit) begin
          m_pc = e.next_pc;
          if (run) m_fetch = 1'b1;
          else m_idle = 1'b1;
        end
      end
      i++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("r_end_halted", halted, 1'b1);
    cur_pc = m_pc;

    // Reset while waiting on rio_out aborts the copy.
    @(negedge clk); rom[cur_pc] = 8'h8E; step = 1'b1; #1;
    @(negedge clk); step = 1'b0; #1;
    @(negedge clk); #1;
    chk("wo_e_out_valid", out_valid, 1'b1); chk("wo_e_retire", retire, 1'b0);
    @(negedge clk); #1;
    chk("wo_w_out_valid", out_valid, 1'b1); chk("wo_w_retire", retire, 1'b0);
    chk("wo_w_addr", instr_addr, cur_pc);
    @(negedge clk); rst_n = 1'b0; out_ready = 1'b1; #1;
    chk("wo_rst_out_valid", out_valid, 1'b0); chk("wo_rst_retire", retire, 1'b0);
    chk("wo_rst_reg_we", reg_we, 1'b0);
    @(negedge clk); #1;
    chk("wo_after_halted", halted, 1'b1); chk("wo_after_pc", instr_addr, 8'h00);
    chk("wo_after_out_valid", out_valid, 1'b0); chk("wo_after_retire", retire, 1'b0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
